// File: rtl/m_pipeline_pkg.sv
// m_pipeline_pkg: constants shared by the register file and its pending-write
// counters.
//   REG_ADDR_W : register address width for the default 256-entry file
//   REG_ZERO   : index of the hardwired zero register
//   PEND_W     : default pending-write counter width
package m_pipeline_pkg;

   localparam int N_REG_DEF  = 256;
   localparam int REG_ADDR_W = $clog2(N_REG_DEF);
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
   localparam int PEND_W     = 2;

endpackage

// File: rtl/m_pend_counter.sv
// m_pend_counter: saturating up/down counter that tracks how many writers to
// one architectural register are still in flight.
//   clk, reset : clock, async active-low reset
//   inc, dec   : one issue / one writeback this cycle
//   cnt        : current outstanding-writer count
//   ovf, unf   : single-cycle events when inc hits max or dec hits zero
module m_pend_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         ovf,
   output logic         unf
);

   localparam logic [W-1:0] CNT_MAX = '1;

   // An issue and a writeback in the same cycle cancel out.
   assign ovf = inc && !dec && (cnt == CNT_MAX);
   assign unf = dec && !inc && (cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (inc && !dec && !ovf) begin
         cnt <= cnt + 1'b1;
      end else if (dec && !inc && !unf) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/m_reg_file_wb.sv
// m_reg_file_wb: architectural register file between WB and ID.
//   clk, reset                 : clock, async active-low reset
//   reg_write_wb/write_reg_wb/write_data_wb : WB write port
//   read_reg_1/2, read_data_1/2 : combinational read ports with WB bypass
//   issue_write, issue_reg      : ID announces a future write to issue_reg
//   busy_1/2                    : read register still has an older writer pending
//   pend_overflow/underflow     : sticky pending-counter error flags
module m_reg_file_wb
   import m_pipeline_pkg::*;
#(
   parameter int N      = 32,
   parameter int N_REG  = 256,
   parameter int PEND_W = m_pipeline_pkg::PEND_W,
   localparam int A     = $clog2(N_REG)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         reg_write_wb,
   input  logic [A-1:0] write_reg_wb,
   input  logic [N-1:0] write_data_wb,
   input  logic [A-1:0] read_reg_1,
   input  logic [A-1:0] read_reg_2,
   output logic [N-1:0] read_data_1,
   output logic [N-1:0] read_data_2,
   input  logic         issue_write,
   input  logic [A-1:0] issue_reg,
   output logic         busy_1,
   output logic         busy_2,
   output logic         pend_overflow,
   output logic         pend_underflow
);

   localparam logic [A-1:0] R0 = A'(REG_ZERO);

   logic [N-1:0]                 regs [N_REG];
   logic [N_REG-1:0][PEND_W-1:0] cnt;
   logic [N_REG-1:0]             ovf_ev;
   logic [N_REG-1:0]             unf_ev;
   logic                         wb_en;
   logic                         iss_en;

   // Register 0 is excluded here so it never stores, bypasses or counts.
   assign wb_en  = reg_write_wb && (write_reg_wb != R0);
   assign iss_en = issue_write  && (issue_reg    != R0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_REG; i++) regs[i] <= '0;
      end else if (wb_en) begin
         regs[write_reg_wb] <= write_data_wb;
      end
   end

   assign cnt[0]    = '0;
   assign ovf_ev[0] = 1'b0;
   assign unf_ev[0] = 1'b0;

   generate
      for (genvar r = 1; r < N_REG; r++) begin : g_pend
         m_pend_counter #(.W(PEND_W)) u_pend (
            .clk   (clk),
            .reset (reset),
            .inc   (iss_en && (issue_reg == A'(r))),
            .dec   (wb_en  && (write_reg_wb == A'(r))),
            .cnt   (cnt[r]),
            .ovf   (ovf_ev[r]),
            .unf   (unf_ev[r])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_overflow  <= 1'b0;
         pend_underflow <= 1'b0;
      end else begin
         pend_overflow  <= pend_overflow  | (|ovf_ev);
         pend_underflow <= pend_underflow | (|unf_ev);
      end
   end

   // Both read ports share one body; port 0 is rs, port 1 is rt.
   logic [1:0][A-1:0] rd_addr;
   logic [1:0][N-1:0] rd_data;
   logic [1:0]        rd_busy;
   logic [1:0]        rd_hit;

   assign rd_addr = {read_reg_2, read_reg_1};

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = '0;
         rd_busy[p] = 1'b0;
         rd_hit[p]  = wb_en && (write_reg_wb == rd_addr[p]);
         if (reset && (rd_addr[p] != R0)) begin
            rd_data[p] = rd_hit[p] ? write_data_wb : regs[rd_addr[p]];
            // The writer retiring this cycle is already served by the bypass.
            rd_busy[p] = (cnt[rd_addr[p]] - PEND_W'(rd_hit[p])) != '0;
         end
      end
   end

   assign read_data_1 = rd_data[0];
   assign read_data_2 = rd_data[1];
   assign busy_1      = rd_busy[0];
   assign busy_2      = rd_busy[1];

endmodule
